// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the EX issue port (0)
// and the self-test/debug port (1); one op in flight, tagged response channel.
module alu_share_arbiter #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_instruction,
   input  logic [31:0] req0_regA,
   input  logic [31:0] req0_regB,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_instruction,
   input  logic [31:0] req1_regA,
   input  logic [31:0] req1_regB,
   output logic [31:0] alu_instruction,
   output logic [31:0] alu_regA,
   output logic [31:0] alu_regB,
   input  logic [31:0] alu_result,
   input  logic [2:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [2:0]  rsp_flags,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t            state_q;
   logic              rr_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       alu_instr_q;
   logic [31:0]       alu_a_q;
   logic [31:0]       alu_b_q;
   logic [31:0]       rsp_result_q;
   logic [2:0]        rsp_flags_q;
   logic              rsp_valid_q;
   logic              rsp_id_q;
   logic              busy_q;

   logic              grant_any_d;
   logic              grant_id_d;
   logic [31:0]       instr_d;
   logic [31:0]       a_d;
   logic [31:0]       b_d;

   // Grant decision: only in IDLE and never while reset is being applied
   always_comb begin
      grant_any_d = 1'b0;
      grant_id_d  = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_any_d = 1'b1;
            grant_id_d  = rr_ptr_q;
         end else if (req1_valid) begin
            grant_any_d = 1'b1;
            grant_id_d  = 1'b1;
         end else if (req0_valid) begin
            grant_any_d = 1'b1;
            grant_id_d  = 1'b0;
         end else begin
            grant_any_d = 1'b0;
         end
      end else begin
         grant_any_d = 1'b0;
      end
      if (grant_id_d) begin
         instr_d = req1_instruction;
         a_d     = req1_regA;
         b_d     = req1_regB;
      end else begin
         instr_d = req0_instruction;
         a_d     = req0_regA;
         b_d     = req0_regB;
      end
   end

   assign req0_ready = grant_any_d && !grant_id_d;
   assign req1_ready = grant_any_d &&  grant_id_d;

   // Control FSM with registered ALU launch and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         cnt_q        <= CNT_ZERO;
         alu_instr_q  <= 32'h0;
         alu_a_q      <= 32'h0;
         alu_b_q      <= 32'h0;
         rsp_result_q <= 32'h0;
         rsp_flags_q  <= 3'b000;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any_d) begin
                  alu_instr_q <= instr_d;
                  alu_a_q     <= a_d;
                  alu_b_q     <= b_d;
                  rr_ptr_q    <= ~grant_id_d;
                  rsp_id_q    <= grant_id_d;
                  cnt_q       <= CNT_LOAD;
                  busy_q      <= 1'b1;
                  state_q     <= EXEC;
               end else begin
                  state_q     <= IDLE;
               end
            end
            EXEC: begin
               // Counter reaching zero means the ALU has settled for EXEC_CYCLES cycles
               if (cnt_q == CNT_ZERO) begin
                  rsp_result_q <= alu_result;
                  rsp_flags_q  <= alu_flags;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  cnt_q        <= cnt_q - CNT_ONE;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= RESP;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign alu_instruction = alu_instr_q;
   assign alu_regA        = alu_a_q;
   assign alu_regB        = alu_b_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_id          = rsp_id_q;
   assign rsp_result      = rsp_result_q;
   assign rsp_flags       = rsp_flags_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: two arbiters (EXEC_CYCLES=1 and 4) share stimulus; s selects which one is checked.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        r0v, r1v, rsp_ready;
   logic [31:0] r0i, r0a, r0b, r1i, r1a, r1b;
   logic        q0r[2], q1r[2], rv[2], rid[2], bz[2];
   logic [31:0] ai[2], aa[2], ab[2], ares[2], rres[2];
   logic [2:0]  afl[2], rfl[2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          s = 0;
   logic        got_id;
   logic [31:0] got_res;
   logic [2:0]  got_fl;
   int          lat;

   // Reference ALU: funct field selects op; flags = {overflow, negative, zero}
   function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        ov;
      ov = 1'b0;
      case (ins[5:0])
         6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         6'h24: r = a & b;
         6'h25: r = a | b;
         default: r = a ^ b;
      endcase
      return {ov, r[31], (r == 32'h0), r};
   endfunction

   assign {afl[0], ares[0]} = alu_model(ai[0], aa[0], ab[0]);
   assign {afl[1], ares[1]} = alu_model(ai[1], aa[1], ab[1]);

   alu_share_arbiter #(.EXEC_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(q0r[0]), .req0_instruction(r0i), .req0_regA(r0a), .req0_regB(r0b),
      .req1_valid(r1v), .req1_ready(q1r[0]), .req1_instruction(r1i), .req1_regA(r1a), .req1_regB(r1b),
      .alu_instruction(ai[0]), .alu_regA(aa[0]), .alu_regB(ab[0]), .alu_result(ares[0]), .alu_flags(afl[0]),
      .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_result(rres[0]), .rsp_flags(rfl[0]),
      .busy(bz[0]));

   alu_share_arbiter #(.EXEC_CYCLES(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(q0r[1]), .req0_instruction(r0i), .req0_regA(r0a), .req0_regB(r0b),
      .req1_valid(r1v), .req1_ready(q1r[1]), .req1_instruction(r1i), .req1_regA(r1a), .req1_regB(r1b),
      .alu_instruction(ai[1]), .alu_regA(aa[1]), .alu_regB(ab[1]), .alu_result(ares[1]), .alu_flags(afl[1]),
      .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_result(rres[1]), .rsp_flags(rfl[1]),
      .busy(bz[1]));

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; r0v = 1'b0; r1v = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present requests and wait (bounded) for a grant; g = granted id or -1
   task automatic issue(input logic v0, input logic v1,
                        input logic [31:0] i0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] i1, input logic [31:0] a1, input logic [31:0] b1,
                        output int g);
      g = -1;
      @(negedge clk);
      r0v = v0; r1v = v1; r0i = i0; r0a = a0; r0b = b0; r1i = i1; r1a = a1; r1b = b1;
      #1;
      for (int k = 0; k < 50; k++) begin
         if (q0r[s] && !q1r[s]) begin g = 0; break; end
         if (q1r[s] && !q0r[s]) begin g = 1; break; end
         @(negedge clk);
         #1;
      end
   endtask

   // Drop requests and collect one response; lat = cycles from call to first rsp_valid
   task automatic get_rsp(input bit bp, output bit got);
      int n;
      got = 1'b0; lat = 0; n = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         r0v = 1'b0; r1v = 1'b0;
         rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         r0i = $urandom; r0a = $urandom; r1i = $urandom; r1b = $urandom;
         #1;
         n++;
         if (rv[s] && lat == 0) lat = n;
         if (rv[s] && rsp_ready) begin
            got_id = rid[s]; got_res = rres[s]; got_fl = rfl[s]; got = 1'b1;
            break;
         end
      end
      rsp_ready = 1'b1;
   endtask

   task automatic test_reset();
      s = 0;
      @(negedge clk);
      rst = 1'b1; r0v = 1'b1; r1v = 1'b1; rsp_ready = 1'b1;
      r0i = 32'hFFFFFFFF; r0a = 32'h1; r0b = 32'h2; r1i = 32'h0; r1a = 32'h3; r1b = 32'h4;
      @(negedge clk);
      #1;
      n_cmp++; if (bz[s] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bz[s]); end
      n_cmp++; if (rv[s] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rv[s]); end
      n_cmp++; if (rid[s] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id: got %b want 0", rid[s]); end
      n_cmp++; if (rres[s] !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_result: got %h want 0", rres[s]); end
      n_cmp++; if (rfl[s] !== 3'b000) begin n_bad++; $display("FAIL reset_rsp_flags: got %b want 000", rfl[s]); end
      n_cmp++; if ({ai[s], aa[s], ab[s]} !== 96'h0) begin n_bad++; $display("FAIL reset_alu: got %h %h %h want 0", ai[s], aa[s], ab[s]); end
      n_cmp++; if ({q0r[s], q1r[s]} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b%b want 00", q0r[s], q1r[s]); end
      rst = 1'b0; r0v = 1'b0; r1v = 1'b0;
   endtask

   task automatic test_single();
      int g;
      bit got;
      s = 0;
      do_reset();
      issue(1'b1, 1'b0, 32'h00010020, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, g);
      n_cmp++; if (g != 0) begin n_bad++; $display("FAIL single_grant: got %0d want 0", g); end
      // Request held high into EXEC: ready must already be gone
      @(negedge clk);
      #1;
      n_cmp++; if (q0r[s] !== 1'b0) begin n_bad++; $display("FAIL single_ready_pulse: got %b want 0", q0r[s]); end
      n_cmp++; if (bz[s] !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bz[s]); end
      n_cmp++; if (ai[s] !== 32'h00010020) begin n_bad++; $display("FAIL single_alu_instr: got %h want 00010020", ai[s]); end
      get_rsp(1'b0, got);
      n_cmp++; if (!got || lat != 1) begin n_bad++; $display("FAIL single_latency: got %0d want 1 (2 after accept)", lat); end
      n_cmp++; if (got_res !== 32'h3) begin n_bad++; $display("FAIL single_result: got %h want 00000003", got_res); end
      n_cmp++; if (got_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", got_id); end
      n_cmp++; if (got_fl !== 3'b000) begin n_bad++; $display("FAIL single_flags: got %b want 000", got_fl); end
      @(negedge clk);
      #1;
      n_cmp++; if (rv[s] !== 1'b0 || bz[s] !== 1'b0) begin n_bad++; $display("FAIL single_idle_after: got valid %b busy %b want 0 0", rv[s], bz[s]); end
   endtask

   task automatic test_overflow();
      int g;
      bit got;
      s = 0;
      issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h00200020, 32'h7FFFFFFF, 32'h00000006, g);
      n_cmp++; if (g != 1) begin n_bad++; $display("FAIL ovf_grant: got %0d want 1", g); end
      get_rsp(1'b0, got);
      n_cmp++; if (!got || lat != 2) begin n_bad++; $display("FAIL ovf_latency: got %0d want 2", lat); end
      n_cmp++; if (got_res !== 32'h80000005) begin n_bad++; $display("FAIL ovf_result: got %h want 80000005", got_res); end
      n_cmp++; if (got_id !== 1'b1) begin n_bad++; $display("FAIL ovf_id: got %b want 1", got_id); end
      n_cmp++; if (got_fl !== 3'b110) begin n_bad++; $display("FAIL ovf_flags: got %b want 110", got_fl); end
   endtask

   task automatic test_contention();
      int n0, n1, nrsp, exp_id, extra;
      s = 0;
      do_reset();
      n0 = 0; n1 = 0; nrsp = 0; exp_id = 0; extra = 0;
      @(negedge clk);
      r0v = 1'b1; r0i = 32'h00010022; r0a = 32'h4; r0b = 32'h3;
      r1v = 1'b1; r1i = 32'h00200024; r1a = 32'hFFFFFFFF; r1b = 32'h1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 200 && nrsp < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (n0 >= 4) r0v = 1'b0;
         if (n1 >= 4) r1v = 1'b0;
         #1;
         if (q0r[s]) n0++;
         if (q1r[s]) n1++;
         if (rv[s]) begin
            n_cmp++; if (rid[s] !== exp_id[0]) begin n_bad++; $display("FAIL cont_id[%0d]: got %b want %0d", nrsp, rid[s], exp_id); end
            n_cmp++; if (rres[s] !== 32'h1) begin n_bad++; $display("FAIL cont_result[%0d]: got %h want 00000001", nrsp, rres[s]); end
            nrsp++;
            exp_id = 1 - exp_id;
         end
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         if (rv[s]) extra++;
      end
      n_cmp++; if (nrsp != 8) begin n_bad++; $display("FAIL cont_count: got %0d want 8", nrsp); end
      n_cmp++; if (n0 != 4 || n1 != 4) begin n_bad++; $display("FAIL cont_grants: got %0d/%0d want 4/4", n0, n1); end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL cont_extra: got %0d want 0", extra); end
   endtask

   task automatic test_backpressure();
      int g;
      bit got;
      s = 0;
      do_reset();
      issue(1'b1, 1'b0, 32'h00010020, 32'd10, 32'd20, 32'h0, 32'h0, 32'h0, g);
      n_cmp++; if (g != 0) begin n_bad++; $display("FAIL bp_grant: got %0d want 0", g); end
      @(negedge clk);
      rsp_ready = 1'b0; r0v = 1'b1; r0i = 32'h00010022; r0a = 32'd50; r0b = 32'd8;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (rv[s]) break;
         @(negedge clk);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         n_cmp++; if (rv[s] !== 1'b1 || rres[s] !== 32'd30 || rfl[s] !== 3'b000) begin n_bad++; $display("FAIL bp_hold[%0d]: got %b %h %b want 1 0000001e 000", k, rv[s], rres[s], rfl[s]); end
         n_cmp++; if (q0r[s] !== 1'b0) begin n_bad++; $display("FAIL bp_no_grant[%0d]: got %b want 0", k, q0r[s]); end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      n_cmp++; if (q0r[s] !== 1'b0) begin n_bad++; $display("FAIL bp_handshake_cycle: got %b want 0", q0r[s]); end
      @(negedge clk);
      #1;
      n_cmp++; if (q0r[s] !== 1'b1) begin n_bad++; $display("FAIL bp_after_handshake: got %b want 1", q0r[s]); end
      get_rsp(1'b0, got);
      n_cmp++; if (!got || got_res !== 32'd42 || got_id !== 1'b0) begin n_bad++; $display("FAIL bp_second_op: got %h id %b want 0000002a id 0", got_res, got_id); end
   endtask

   task automatic test_exec4();
      int g, n;
      s = 1;
      do_reset();
      issue(1'b1, 1'b0, 32'h00010025, 32'h000000F0, 32'h0000000F, 32'h0, 32'h0, 32'h0, g);
      n_cmp++; if (g != 0) begin n_bad++; $display("FAIL ex4_grant: got %0d want 0", g); end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         r0v = 1'b0; r0i = $urandom; r0a = $urandom; r0b = $urandom;
         #1;
         n++;
         if (rv[s]) break;
         n_cmp++; if ({ai[s], aa[s], ab[s]} !== {32'h00010025, 32'h000000F0, 32'h0000000F}) begin n_bad++; $display("FAIL ex4_alu_stable[%0d]: got %h %h %h", n, ai[s], aa[s], ab[s]); end
      end
      n_cmp++; if (n != 5) begin n_bad++; $display("FAIL ex4_latency: got %0d want 5", n); end
      n_cmp++; if (rres[s] !== 32'h000000FF || rid[s] !== 1'b0) begin n_bad++; $display("FAIL ex4_result: got %h id %b want 000000ff id 0", rres[s], rid[s]); end
      n_cmp++; if (ai[s] !== 32'h00010025) begin n_bad++; $display("FAIL ex4_alu_hold_resp: got %h want 00010025", ai[s]); end
      @(negedge clk);
   endtask

   task automatic test_midreset();
      int g;
      bit got;
      s = 0;
      do_reset();
      issue(1'b1, 1'b0, 32'h00010020, 32'd5, 32'd6, 32'h0, 32'h0, 32'h0, g);
      @(negedge clk);
      rst = 1'b1; r0v = 1'b0;
      #1;
      n_cmp++; if (bz[s] !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", bz[s]); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bz[s] !== 1'b0 || rv[s] !== 1'b0) begin n_bad++; $display("FAIL mid_cleared: got busy %b valid %b want 0 0", bz[s], rv[s]); end
      n_cmp++; if ({ai[s], aa[s], ab[s]} !== 96'h0) begin n_bad++; $display("FAIL mid_alu_zero: got %h %h %h want 0", ai[s], aa[s], ab[s]); end
      // Pointer reset to 0 means requester 0 wins this contention
      issue(1'b1, 1'b1, 32'h00010020, 32'd7, 32'd8, 32'h00010024, 32'h3, 32'h1, g);
      n_cmp++; if (g != 0) begin n_bad++; $display("FAIL mid_rr_ptr: got %0d want 0", g); end
      get_rsp(1'b0, got);
      n_cmp++; if (!got || got_res !== 32'd15 || got_id !== 1'b0) begin n_bad++; $display("FAIL mid_followup: got %h id %b want 0000000f id 0", got_res, got_id); end
   endtask

   task automatic test_random(input int sel);
      int g, exp_g, rr, kind;
      bit got;
      logic v0, v1;
      logic [31:0] i0, a0, b0, i1, a1, b1;
      logic [34:0] exp;
      logic [5:0] functs [5];
      functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24; functs[3] = 6'h25; functs[4] = 6'h26;
      s = sel;
      do_reset();
      rr = 0;
      for (int t = 0; t < 25; t++) begin
         kind = $urandom_range(0, 2);
         v0 = (kind != 1); v1 = (kind != 0);
         i0 = {26'($urandom), functs[$urandom_range(0, 4)]};
         i1 = {26'($urandom), functs[$urandom_range(0, 4)]};
         a0 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
         b0 = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
         b1 = $urandom;
         exp_g = (v0 && v1) ? rr : (v1 ? 1 : 0);
         rr = 1 - exp_g;
         exp = (exp_g == 1) ? alu_model(i1, a1, b1) : alu_model(i0, a0, b0);
         issue(v0, v1, i0, a0, b0, i1, a1, b1, g);
         n_cmp++; if (g != exp_g) begin n_bad++; $display("FAIL rnd%0d_grant[%0d]: got %0d want %0d", sel, t, g, exp_g); end
         get_rsp(1'b1, got);
         n_cmp++; if (!got || lat != ((sel == 1) ? 5 : 2)) begin n_bad++; $display("FAIL rnd%0d_latency[%0d]: got %0d want %0d", sel, t, lat, (sel == 1) ? 5 : 2); end
         n_cmp++; if (got_id !== exp_g[0]) begin n_bad++; $display("FAIL rnd%0d_id[%0d]: got %b want %0d", sel, t, got_id, exp_g); end
         n_cmp++; if ({got_fl, got_res} !== exp) begin n_bad++; $display("FAIL rnd%0d_data[%0d]: got %b %h want %b %h", sel, t, got_fl, got_res, exp[34:32], exp[31:0]); end
      end
   endtask

   initial begin
      rst = 1'b1; r0v = 1'b0; r1v = 1'b0; rsp_ready = 1'b0;
      r0i = 32'h0; r0a = 32'h0; r0b = 32'h0; r1i = 32'h0; r1a = 32'h0; r1b = 32'h0;
      test_reset();
      test_single();
      test_overflow();
      test_contention();
      test_backpressure();
      test_exec4();
      test_midreset();
      test_random(0);
      test_random(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
